// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared types and constants for the two-master I/O bus arbiter.
//   NUM_M        number of masters sharing the bus
//   arb_state_t  arbiter FSM state
//   mid_t        master identifier (0 = RISC-V core, 1 = loader/DMA)
package io_arb_pkg;

  localparam int NUM_M = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } arb_state_t;

  typedef logic [0:0] mid_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if: one strobe-style I/O bus port.
//   address, read_strobe, write_strobe, write_data  driven by the requester
//   read_data, ready                                 returned by the responder
// Modports: master = requester side, slave = responder side.
interface io_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read_strobe;
  logic              write_strobe;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (
    output address, read_strobe, write_strobe, write_data,
    input  read_data, ready
  );

  modport slave (
    input  address, read_strobe, write_strobe, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/io_arb_req_slot.sv
// io_arb_req_slot: single-entry request latch for one master, with sticky
// overrun detection.
//   clk, reset   clock, synchronous active-high reset
//   addr_i       request address
//   rd_stb_i     one-cycle read strobe
//   wr_stb_i     one-cycle write strobe (wins over a simultaneous read)
//   wdata_i      write data, sampled with the strobe
//   clr_i        retire the held request (end of its bus cycle)
//   pending_o    a request is held
//   is_wr_o      held request is a write
//   addr_o       held address
//   wdata_o      held write data
//   ovr_o        sticky: a strobe arrived while a request was held
module io_arb_req_slot #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              rd_stb_i,
  input  logic              wr_stb_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              clr_i,
  output logic              pending_o,
  output logic              is_wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              ovr_o
);

  logic              pending_q, pending_d;
  logic              is_wr_q, is_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ovr_q, ovr_d;
  logic              stb_s;

  // Next-state: clear on retire, load when free, flag overrun when busy.
  // A strobe on the retire edge still sees the slot busy and is an overrun.
  always_comb begin
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovr_d   = ovr_q;
    stb_s   = rd_stb_i | wr_stb_i;
    if (clr_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (stb_s && !pending_q) begin
      pending_d = 1'b1;
      is_wr_d   = wr_stb_i;
      addr_d    = addr_i;
      if (wr_stb_i) begin
        wdata_d = wdata_i;
      end else begin
        wdata_d = wdata_q;
      end
    end else if (stb_s) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      is_wr_q   <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      ovr_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ovr_q     <= ovr_d;
    end
  end

  assign pending_o = pending_q;
  assign is_wr_o   = is_wr_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign ovr_o     = ovr_q;

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares one strobe-style I/O bus between the RISC-V core
// (m0) and the loader/DMA engine (m1). One transaction at a time, registered
// bus strobes for exactly one cycle, read data captured per master, one-cycle
// ready pulse back to the owner.
//   clk, reset  clock, synchronous active-high reset
//   m0, m1      master ports (slave modport: requests in, read_data/ready out)
//   io          bridge port (master modport: requests out, read_data in)
//   ovr         sticky overrun flag per master, bit n = master n
// Build option IO_ARB_FIXED_PRIO_EN: m0 always wins a tie instead of
// round-robin.
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  io_bus_arbiter_if.slave  m0,
  io_bus_arbiter_if.slave  m1,
  io_bus_arbiter_if.master io,
  output logic [NUM_M-1:0] ovr
);

  logic [NUM_M-1:0]  pend_s, is_wr_s, clr_s, ovr_s;
  logic [ADDR_W-1:0] slot_addr_s  [NUM_M];
  logic [DATA_W-1:0] slot_wdata_s [NUM_M];
  mid_t              winner_s;

  arb_state_t        state_q, state_d;
  mid_t              grant_q, grant_d;
  mid_t              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [DATA_W-1:0] io_wdata_q, io_wdata_d;
  logic              io_rd_q, io_rd_d;
  logic              io_wr_q, io_wr_d;
  logic [DATA_W-1:0] rdata_q [NUM_M];
  logic [DATA_W-1:0] rdata_d [NUM_M];
  logic [NUM_M-1:0]  ready_q, ready_d;

  io_arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk(clk), .reset(reset),
    .addr_i(m0.address), .rd_stb_i(m0.read_strobe), .wr_stb_i(m0.write_strobe),
    .wdata_i(m0.write_data), .clr_i(clr_s[0]),
    .pending_o(pend_s[0]), .is_wr_o(is_wr_s[0]), .addr_o(slot_addr_s[0]),
    .wdata_o(slot_wdata_s[0]), .ovr_o(ovr_s[0])
  );

  io_arb_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk(clk), .reset(reset),
    .addr_i(m1.address), .rd_stb_i(m1.read_strobe), .wr_stb_i(m1.write_strobe),
    .wdata_i(m1.write_data), .clr_i(clr_s[1]),
    .pending_o(pend_s[1]), .is_wr_o(is_wr_s[1]), .addr_o(slot_addr_s[1]),
    .wdata_o(slot_wdata_s[1]), .ovr_o(ovr_s[1])
  );

  // Winner select: a lone pending master wins; a tie goes to the master that
  // was not served last (or always to m0 in fixed-priority builds).
  always_comb begin
    winner_s = 1'b0;
    if (pend_s == 2'b11) begin
`ifdef IO_ARB_FIXED_PRIO_EN
      winner_s = 1'b0;
`else
      winner_s = ~last_grant_q;
`endif
    end else if (pend_s[1]) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // FSM next-state and datapath: IDLE loads the bus registers from the
  // winner's slot; BUS retires the slot, captures read data and raises ready.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    io_addr_d    = io_addr_q;
    io_wdata_d   = io_wdata_q;
    io_rd_d      = 1'b0;
    io_wr_d      = 1'b0;
    rdata_d      = rdata_q;
    ready_d      = 2'b00;
    clr_s        = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|pend_s) begin
          grant_d   = winner_s;
          io_addr_d = slot_addr_s[winner_s];
          if (is_wr_s[winner_s]) begin
            io_wr_d    = 1'b1;
            io_wdata_d = slot_wdata_s[winner_s];
          end else begin
            io_rd_d = 1'b1;
          end
          state_d = ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        // The bridge returns read data combinationally during the strobe.
        if (io_rd_q) begin
          rdata_d[grant_q] = io.read_data;
        end else begin
          rdata_d[grant_q] = rdata_q[grant_q];
        end
        clr_s[grant_q]   = 1'b1;
        ready_d[grant_q] = 1'b1;
        last_grant_d     = grant_q;
        state_d          = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbiter state and registered outputs; last_grant resets to m1 so m0
  // takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      io_addr_q    <= {ADDR_W{1'b0}};
      io_wdata_q   <= {DATA_W{1'b0}};
      io_rd_q      <= 1'b0;
      io_wr_q      <= 1'b0;
      rdata_q[0]   <= {DATA_W{1'b0}};
      rdata_q[1]   <= {DATA_W{1'b0}};
      ready_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      io_addr_q    <= io_addr_d;
      io_wdata_q   <= io_wdata_d;
      io_rd_q      <= io_rd_d;
      io_wr_q      <= io_wr_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
    end
  end

  assign io.address      = io_addr_q;
  assign io.write_data   = io_wdata_q;
  assign io.read_strobe  = io_rd_q;
  assign io.write_strobe = io_wr_q;
  assign m0.read_data    = rdata_q[0];
  assign m1.read_data    = rdata_q[1];
  assign m0.ready        = ready_q[0];
  assign m1.ready        = ready_q[1];
  assign ovr             = ovr_s;

endmodule
